// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port, occupancy counter,
// almost-full/almost-empty flags and sticky overflow/underflow errors.
module sync_fifo #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int AFULL_LVL  = 240,
  parameter int AEMPTY_LVL = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              full_o,
  output logic              afull_o,
  output logic              empty_o,
  output logic              aempty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              ovf_o,
  output logic              udf_o,
  input  logic              clr_err_i
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] AE_C = (ADDR_W+1)'(AEMPTY_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  assign full_o   = (count_o == DEPTH_C);
  assign empty_o  = (count_o == '0);
  assign afull_o  = (count_o >= AF_C);
  assign aempty_o = (count_o <= AE_C);

  // Full/empty gating alone resolves the simultaneous read+write corners.
  assign wr_ok = wr_en_i & ~full_o & ~rst_i;
  assign rd_ok = rd_en_i & ~empty_o & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_ok;
      if (rd_ok) rd_data_o <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else begin
      unique case ({wr_ok, rd_ok})
        2'b10:   count_o <= count_o + (ADDR_W+1)'(1);
        2'b01:   count_o <= count_o - (ADDR_W+1)'(1);
        default: count_o <= count_o;
      endcase
    end
  end

  // A new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else begin
      ovf_o <= (wr_en_i & full_o) | (ovf_o & ~clr_err_i);
      udf_o <= (rd_en_i & empty_o) | (udf_o & ~clr_err_i);
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: directed stimulus feeds an expected
// read queue, a monitor pops and compares on every rd_valid_o pulse.
module tb_sync_fifo;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        full, afull, empty, aempty;
  logic [8:0]  count;
  logic        ovf, udf;
  logic        clr;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = '0;
  bit          m_ovf = 0;
  bit          m_udf = 0;

  sync_fifo dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .rd_en_i    (rd_en),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .full_o     (full),
    .afull_o    (afull),
    .empty_o    (empty),
    .aempty_o   (aempty),
    .count_o    (count),
    .ovf_o      (ovf),
    .udf_o      (udf),
    .clr_err_i  (clr)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rd_valid", 64'(rd_valid), 64'd0);
      end else begin
        chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
      end
    end else if (exp_q.size() != 0) begin
      chk("rd_valid_latency", 64'(rd_valid), 64'd1);
      void'(exp_q.pop_front());
    end
  end

  task automatic chk_state();
    int n;
    n = mq.size();
    chk("count",  64'(count),  64'(n));
    chk("full",   64'(full),   64'(n == 256));
    chk("empty",  64'(empty),  64'(n == 0));
    chk("afull",  64'(afull),  64'(n >= 240));
    chk("aempty", 64'(aempty), 64'(n <= 16));
    chk("ovf",    64'(ovf),    64'(m_ovf));
    chk("udf",    64'(udf),    64'(m_udf));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit w, input logic [31:0] d,
                      input bit r, input bit c);
    bit wa, ra;
    wr_en = w; wr_data = d; rd_en = r; clr = c;
    wa = w && mq.size() < 256;
    ra = r && mq.size() > 0;
    m_ovf = (w && mq.size() == 256) || (m_ovf && !c);
    m_udf = (r && mq.size() == 0) || (m_udf && !c);
    if (ra) begin
      last_rd = mq.pop_front();
      exp_q.push_back(last_rd);
    end
    if (wa) mq.push_back(d);
    @(negedge clk);
    wr_en = 0; rd_en = 0; clr = 0;
    chk_state();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"},  64'(count),    64'd0);
    chk({tag, "_empty"},  64'(empty),    64'd1);
    chk({tag, "_aempty"}, 64'(aempty),   64'd1);
    chk({tag, "_full"},   64'(full),     64'd0);
    chk({tag, "_afull"},  64'(afull),    64'd0);
    chk({tag, "_rdata"},  64'(rd_data),  64'd0);
    chk({tag, "_rvalid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_ovf"},    64'(ovf),      64'd0);
    chk({tag, "_udf"},    64'(udf),      64'd0);
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_data = '0; rd_en = 0; clr = 0;
    #1;
    chk_reset_vals("rst0");
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // four words in, four out
    step(1, 250, 0, 0);
    step(1, 500, 0, 0);
    step(1, 1000, 0, 0);
    step(1, 1250, 0, 0);
    chk("cnt4", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    chk("cnt0", 64'(count), 64'd0);
    chk("empty_end", 64'(empty), 64'd1);

    // fill to full, overflow, drain
    for (int i = 0; i < 256; i++) begin
      step(1, 32'(5 * i), 0, 0);
      if (i == 238) chk("afull_239", 64'(afull), 64'd0);
      if (i == 239) chk("afull_240", 64'(afull), 64'd1);
      if (i == 254) chk("full_255", 64'(full), 64'd0);
    end
    chk("full_256", 64'(full), 64'd1);
    step(1, 32'hdead, 0, 0);
    chk("ovf_set", 64'(ovf), 64'd1);
    chk("cnt_ovf", 64'(count), 64'd256);
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 1, 0);
      if (count == 9'd17) chk("aempty_17", 64'(aempty), 64'd0);
      if (count == 9'd16) chk("aempty_16", 64'(aempty), 64'd1);
    end
    chk("last_1275", 64'(rd_data), 64'd1275);
    step(0, 0, 0, 1);

    // underflow and clear priority
    step(0, 0, 1, 0);
    chk("udf_set", 64'(udf), 64'd1);
    chk("udf_hold_data", 64'(rd_data), 64'd1275);
    step(0, 0, 0, 1);
    chk("udf_clr", 64'(udf), 64'd0);
    step(0, 0, 1, 1);
    chk("udf_wins", 64'(udf), 64'd1);
    step(0, 0, 0, 1);

    // simultaneous read/write at full and at empty
    for (int i = 0; i < 256; i++) step(1, 32'(i + 7), 0, 0);
    step(1, 32'hbeef, 1, 0);
    chk("full_both_cnt", 64'(count), 64'd255);
    chk("full_both_ovf", 64'(ovf), 64'd1);
    for (int i = 0; i < 255; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(1, 42, 1, 0);
    chk("empty_both_cnt", 64'(count), 64'd1);
    chk("empty_both_udf", 64'(udf), 64'd1);
    chk("empty_both_nv", 64'(rd_valid), 64'd0);
    step(0, 0, 1, 1);
    chk("word42", 64'(rd_data), 64'd42);

    // steady occupancy of 100 across two pointer wraps
    for (int i = 0; i < 100; i++) step(1, 32'(1000 + i), 0, 0);
    for (int i = 0; i < 600; i++) step(1, 32'(2000 + i), 1, 0);
    chk("steady_cnt", 64'(count), 64'd100);
    for (int i = 0; i < 100; i++) step(0, 0, 1, 0);

    // asynchronous reset with 50 stored
    for (int i = 0; i < 50; i++) step(1, 32'(300 + i), 0, 0);
    chk("cnt50", 64'(count), 64'd50);
    #2 rst = 1;
    #1 chk_reset_vals("arst");
    wr_en = 1; wr_data = 32'd999; rd_en = 1;
    @(negedge clk);
    chk_reset_vals("inrst");
    wr_en = 0; rd_en = 0;
    rst = 0;
    mq.delete();
    m_ovf = 0; m_udf = 0;
    step(1, 777, 0, 0);
    step(0, 0, 1, 0);
    chk("post_rst_data", 64'(rd_data), 64'd777);
    chk("post_rst_cnt", 64'(count), 64'd0);

    @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
